secded_encoder_stream: RTL and testbench

- Streaming Hamming SECDED(32,26) encoder: accepts 26-bit data words and emits 32-bit codewords in the codeword layout our SECDED decoder consumes.
- Sits directly upstream of that decoder.
- Two-stage registered pipeline with valid/ready handshakes on both sides.
- Built-in error injection (single/double bit flips) so decoder correction and double-error detection can be exercised in-system.
- Counts delivered codewords.

---
 rtl/secded_encoder_stream.sv | 132 +++++++++++++
 tb/tb_secded_encoder_stream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/secded_encoder_stream.sv
// Streaming SECDED(32,26) encoder: two-stage valid/ready pipeline with optional
// single/double bit-flip injection on the emitted codeword and a saturating delivery counter.
module secded_encoder_stream #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:25]      in_data,
    input  logic [1:0]       inj_mode,
    input  logic [4:0]       inj_pos_a,
    input  logic [4:0]       inj_pos_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:31]      out_code,
    output logic [CNT_W-1:0] word_count,
    input  logic             clr_count
);

    logic             adv1, adv2;
    logic             s1_valid_q, s1_valid_d;
    logic [0:25]      s1_data_q, s1_data_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic [4:0]       s1_pos_a_q, s1_pos_a_d;
    logic [4:0]       s1_pos_b_q, s1_pos_b_d;
    logic             out_valid_q, out_valid_d;
    logic [0:31]      out_code_q, out_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:31]      enc;
    logic [0:31]      flip;
    logic [4:0]       syn;

    assign adv2      = !out_valid_q || out_ready;
    assign adv1      = !s1_valid_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign word_count = cnt_q;

    // Data fills non-power-of-two indices; check bits are the XOR of the indices of set data
    // bits, which drives the overall syndrome of a clean word to zero.
    always_comb begin
        int unsigned j;
        enc = '0;
        syn = '0;
        j   = 0;
        for (int i = 1; i < 32; i++) begin
            if ((i & (i - 1)) != 0) begin
                enc[i] = s1_data_q[j];
                if (s1_data_q[j]) begin
                    syn = syn ^ 5'(i);
                end
                j++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            enc[1 << k] = syn[k];
        end
        enc[0] = ^enc[1:31];
    end

    // Equal positions in double mode collapse to a single flip.
    always_comb begin
        flip = '0;
        case (s1_mode_q)
            2'd1: flip[s1_pos_a_q] = 1'b1;
            2'd2: begin
                flip[s1_pos_a_q] = 1'b1;
                flip[s1_pos_b_q] = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_mode_d   = s1_mode_q;
        s1_pos_a_d  = s1_pos_a_q;
        s1_pos_b_d  = s1_pos_b_q;
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        cnt_d       = cnt_q;

        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d  = in_data;
                s1_mode_d  = inj_mode;
                s1_pos_a_d = inj_pos_a;
                s1_pos_b_d = inj_pos_b;
            end
        end

        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_code_d = enc ^ flip;
            end
        end

        if (clr_count) begin
            cnt_d = '0;
        end else if (out_valid_q && out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_mode_q   <= '0;
            s1_pos_a_q  <= '0;
            s1_pos_b_q  <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_mode_q   <= s1_mode_d;
            s1_pos_a_q  <= s1_pos_a_d;
            s1_pos_b_q  <= s1_pos_b_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_secded_encoder_stream.sv
// Bench for secded_encoder_stream: directed codeword checks, stalled and random streams
// against a reference encoder, counter saturation/clear and asynchronous reset.
module tb_secded_encoder_stream;

    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [0:25]      in_data;
    logic [1:0]       inj_mode;
    logic [4:0]       inj_pos_a;
    logic [4:0]       inj_pos_b;
    logic             out_valid;
    logic             out_ready;
    logic [0:31]      out_code;
    logic [CNT_W-1:0] word_count;
    logic             clr_count;

    typedef struct {
        logic [0:31] code;
        logic [1:0]  mode;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;
    bit   saw_lo;

    secded_encoder_stream #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .inj_mode   (inj_mode),
        .inj_pos_a  (inj_pos_a),
        .inj_pos_b  (inj_pos_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .word_count (word_count),
        .clr_count  (clr_count)
    );

    always #5 clk = ~clk;

    // Reference: data in ascending non-power-of-two slots, each check bit 2^k is the parity of
    // the data slots whose index has bit k set, slot 0 makes the whole word even.
    function automatic logic [0:31] model(logic [0:25] d, logic [1:0] m, int a, int b);
        logic [0:31] c = '0;
        int k = 0;
        for (int i = 1; i < 32; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[k];
                k++;
            end
        end
        for (int p = 0; p < 5; p++) begin
            logic par = 1'b0;
            for (int i = 1; i < 32; i++)
                if (((i >> p) & 1) == 1 && (i & (i - 1)) != 0) par ^= c[i];
            c[1 << p] = par;
        end
        c[0] = ^c;
        if (m == 2'd1) c[a] = ~c[a];
        else if (m == 2'd2) begin
            c[a] = ~c[a];
            if (b != a) c[b] = ~c[b];
        end
        return c;
    endfunction

    // Decoder view: index syndrome in bits 4:0, overall parity in bit 5; zero for a clean word.
    function automatic int synd(logic [0:31] c);
        int s = 0;
        for (int i = 1; i < 32; i++) if (c[i]) s ^= i;
        return s | (int'(^c) << 5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void count_hs();
        exp_cnt = (exp_cnt < CMAX) ? exp_cnt + 1 : CMAX;
    endfunction

    task automatic send_one(input logic [0:25] d, input logic [1:0] m, input int a, input int b,
                            input logic [31:0] exp_code);
        int lat;
        in_valid  = 1'b1;
        in_data   = d;
        inj_mode  = m;
        inj_pos_a = 5'(a);
        inj_pos_b = 5'(b);
        #1;
        chk("in_ready_idle", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("latency", lat, 2);
        chk("directed_code", out_code, exp_code);
        chk("model_code", out_code, model(d, m, a, b));
        tick();
        count_hs();
        chk("count_after_hs", 32'(word_count), exp_cnt);
    endtask

    task automatic run_stream(input int n, input bit rnd, input int st_lo, input int st_hi);
        int          sent = 0;
        int          rcv = 0;
        bit          stall_prev = 1'b0;
        logic [0:31] prev_code = '0;
        exp_t        e;
        saw_lo = 1'b0;
        for (int cyc = 0; cyc < 600 && rcv < n; cyc++) begin
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= st_lo && cyc <= st_hi);
            if (sent < n && (!rnd || $urandom_range(0, 1) == 1)) begin
                in_valid  = 1'b1;
                in_data   = rnd ? 26'($urandom) : 26'(sent * 1234567 + 99);
                inj_mode  = rnd ? 2'($urandom_range(0, 3)) : 2'd0;
                inj_pos_a = 5'($urandom_range(0, 31));
                inj_pos_b = 5'($urandom_range(0, 31));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_code", out_code, prev_code);
            end
            if (!in_ready) saw_lo = 1'b1;
            if (out_valid && out_ready) begin
                chk("queue_nonempty", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("stream_code", out_code, e.code);
                    if (e.mode == 2'd0 || e.mode == 2'd3)
                        chk("clean_syndrome", synd(out_code), 0);
                end
                rcv++;
                count_hs();
            end
            stall_prev = out_valid && !out_ready;
            prev_code  = out_code;
            if (in_valid && in_ready) begin
                e.code = model(in_data, inj_mode, int'(inj_pos_a), int'(inj_pos_b));
                e.mode = inj_mode;
                q.push_back(e);
                sent++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_received", rcv, n);
        chk("stream_count", 32'(word_count), exp_cnt);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        inj_mode  = '0;
        inj_pos_a = '0;
        inj_pos_b = '0;
        out_ready = 1'b1;
        clr_count = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_code", out_code, 0);
        chk("reset_count", 32'(word_count), 0);
        chk("reset_in_ready", 32'(in_ready), 1);

        send_one(26'h0000000, 2'd0, 0, 0, 32'h00000000);
        send_one(26'h3FFFFFF, 2'd0, 0, 0, 32'hFFFFFFFF);
        send_one(26'h2000000, 2'd0, 0, 0, 32'hF0000000);
        send_one(26'h0000000, 2'd1, 5, 0, 32'h04000000);
        send_one(26'h0000000, 2'd2, 3, 9, 32'h10400000);
        send_one(26'h0000000, 2'd2, 7, 7, 32'h01000000);
        send_one(26'h0000000, 2'd3, 4, 6, 32'h00000000);

        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        exp_cnt = 0;
        chk("clear_count", 32'(word_count), 0);

        run_stream(5, 1'b0, 3, 7);
        chk("stall_in_ready_low", 32'(saw_lo), 1);
        chk("stall_final_count", 32'(word_count), 5);

        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        exp_cnt = 0;
        run_stream(20, 1'b0, -1, -1);
        chk("saturated_count", 32'(word_count), 15);

        run_stream(60, 1'b1, -1, -1);

        // Clear coincident with a handshake of a held word.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 26'h1234567;
        inj_mode  = 2'd0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("held_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        exp_cnt = 0;
        chk("clear_wins", 32'(word_count), 0);
        chk("clear_hs_drained", 32'(out_valid), 0);

        // Asynchronous reset in the middle of a stall.
        send_one(26'h0ABCDEF, 2'd0, 0, 0, model(26'h0ABCDEF, 2'd0, 0, 0));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 26'h155AA55;
        tick();
        in_data = 26'h0F0F0F0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_reset_valid", 32'(out_valid), 1);
        chk("pre_reset_in_ready", 32'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_count", 32'(word_count), 0);
        chk("async_out_code", out_code, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 1);
        tick();
        tick();
        chk("inflight_discarded", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
